shift_sub_divider: RTL and testbench
====================================

Name: shift_sub_divider

Overview:
- Sequential restoring divider.
- Divides a 2W-bit dividend by a W-bit divisor and returns a W-bit quotient and a W-bit remainder.
- It is the inverse of the team's 4x4 shift-add multiplier and shares its START/READY handshake, so a multiplier product can be fed straight back in for checking.
- It is a single-clock datapath block with no bus interface.

Parameters:
- W, 4, divisor/quotient/remainder width; dividend width is 2*W; W >= 2.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- START  input  1  request; sampled only while READY=1.
- DIVIDEND  input  2*W  dividend; captured on the accept edge.
- DIVISOR  input  W  divisor; captured on the accept edge.
- READY  output  1  1 = idle and results valid; 0 = busy.
- QUOTIENT  output  W  quotient of the last completed operation.
- REMAINDER  output  W  remainder of the last completed operation.
- OVF  output  1  last operation overflowed: DIVIDEND[2W-1:W] >= DIVISOR, divisor nonzero.
- DVZ  output  1  last operation had DIVISOR = 0.

Behaviour:
- Reset (RN=0, asynchronous) puts the block in state IDLE with READY=1, QUOTIENT=0, REMAINDER=0, OVF=0, DVZ=0. All internal registers are cleared.
- States: IDLE and RUN. READY = (state == IDLE), driven from the register, never combinationally from START.
- Accept edge: START=1 while in IDLE.
  - If DIVISOR == 0: stay in IDLE; QUOTIENT = all ones, REMAINDER = 0, DVZ=1, OVF=0. READY never drops.
  - Else if DIVIDEND[2W-1:W] >= DIVISOR: stay in IDLE; QUOTIENT = all ones, REMAINDER = 0, OVF=1, DVZ=0. DVZ takes priority over OVF.
  - Otherwise go to RUN and load:
    - partial remainder PR (W+1 bits) = {0, DIVIDEND[2W-1:W]};
    - shift register QS = DIVIDEND[W-1:0];
    - iteration counter CNT = 0;
    - divisor register.
    - Clear OVF and DVZ.
- RUN, one iteration per clock:
  - T = {PR[W-1:0], QS[W-1]} - {0, divisor}, computed in W+1 bits.
  - If T is non-negative: PR = T and shift 1 into QS LSB.
  - Else: PR = {PR[W-1:0], QS[W-1]} and shift 0 into QS LSB.
  - CNT increments each iteration.
- After iteration W (CNT == W-1 at the edge): go to IDLE, QUOTIENT = QS, REMAINDER = PR[W-1:0], READY=1.
- Latency: READY is low for exactly W cycles after the accept edge. Results are valid in the cycle READY rises.
- QUOTIENT, REMAINDER, OVF and DVZ hold their previous values throughout RUN. They change only on a completion edge or an error accept edge.
- START while READY=0 is ignored (see Optional Feature). START held high continuously re-triggers on every cycle READY=1, including the rise cycle, so back-to-back operations have no bubble.
- Invariant on normal completion: DIVIDEND == QUOTIENT*DIVISOR + REMAINDER and REMAINDER < DIVISOR.
- RN asserted mid-RUN aborts immediately and returns to reset values. The partial result is discarded.
- DIVIDEND and DIVISOR may change freely after the accept edge without effect.

Optional Feature:
- Macro: DIV_ABORT_EN.
- Defined: START=1 during RUN aborts the current operation and re-accepts using the current DIVIDEND/DIVISOR, applying the same error checks as in IDLE.
  - An error result lands in IDLE on that edge.
  - Otherwise RUN restarts with CNT=0, and READY stays low for W more cycles.
  - The aborted operation never updates the outputs.
- Undefined: START during RUN is ignored as described above.

Test Plan (W=4):
- DIVIDEND=100, DIVISOR=7, START pulse -> READY low exactly 4 cycles, then QUOTIENT=14, REMAINDER=2, OVF=0, DVZ=0.
- DIVIDEND=119, DIVISOR=8 -> QUOTIENT=14, REMAINDER=7 after 4 cycles. Then START held high with DIVIDEND=15, DIVISOR=1 -> immediate re-accept with no idle gap; result QUOTIENT=15, REMAINDER=0.
- DIVIDEND=255, DIVISOR=15 -> READY stays 1, OVF=1, QUOTIENT=15, REMAINDER=0. Repeat with DIVISOR=0, DIVIDEND=45 -> DVZ=1, OVF=0, QUOTIENT=15.
- Start 100/7, drive RN=0 after 2 RUN cycles -> READY=1, QUOTIENT=0, REMAINDER=0, OVF=0, DVZ=0 asynchronously, before the next CK edge.
- Start 100/7, then START with DIVIDEND=50, DIVISOR=3 after 2 cycles:
  - without DIV_ABORT_EN -> QUOTIENT=14, REMAINDER=2 after 4 total cycles;
  - with DIV_ABORT_EN -> QUOTIENT=16 would overflow, so OVF=1 and READY=1 on that edge.
  - Also with DIV_ABORT_EN: 50/5 -> QUOTIENT=10, REMAINDER=0, 4 cycles after the restart.
- Exhaustive sweep: all dividends 0..255 × divisors 1..15 against a reference model, including OVF/DVZ cases and the 4-cycle latency.

Source files
------------

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider.
// Divides a 2W-bit dividend by a W-bit divisor in W clock cycles and returns
// a W-bit quotient and a W-bit remainder. It uses the same START/READY
// handshake as the shift-add multiplier, so products can be looped straight
// back in. Divide-by-zero and quotient overflow are flagged on the accept
// edge without entering RUN.
// Optional build macro: DIV_ABORT_EN. When it is defined, START during RUN
// aborts the current operation and re-accepts using the present inputs.
module shift_sub_divider #(
    parameter int W = 4
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic [2*W-1:0]   DIVIDEND,
    input  logic [W-1:0]     DIVISOR,
    output logic             READY,
    output logic [W-1:0]     QUOTIENT,
    output logic [W-1:0]     REMAINDER,
    output logic             OVF,
    output logic             DVZ
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W:0]         pr_q,   pr_d;      // partial remainder
    logic [W-1:0]       qs_q,   qs_d;      // dividend low half / quotient bits
    logic [W-1:0]       dvs_q,  dvs_d;     // captured divisor
    logic [CNT_W-1:0]   cnt_q,  cnt_d;     // iteration counter
    logic [W-1:0]       quot_q, quot_d;
    logic [W-1:0]       rem_q,  rem_d;
    logic               ovf_q,  ovf_d;
    logic               dvz_q,  dvz_d;

    logic               accept;
    logic [2*W:0]       step;              // {next PR, next QS}

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor and keep the difference only if
    // it did not go negative. The subtraction is done one bit wider than the
    // partial remainder so the sign bit is a clean borrow flag.
    function automatic logic [2*W:0] div_step(
        input logic [W:0]   pr,
        input logic [W-1:0] qs,
        input logic [W-1:0] dvs
    );
        logic [W+1:0] wide;
        logic [W:0]   shifted;
        shifted = {pr[W-1:0], qs[W-1]};
        wide    = {pr, qs[W-1]} - {2'b00, dvs};
        if (!wide[W+1]) begin
            return {wide[W:0], qs[W-2:0], 1'b1};
        end else begin
            return {shifted, qs[W-2:0], 1'b0};
        end
    endfunction

`ifdef DIV_ABORT_EN
    // START is honoured in both states: in RUN it discards the current
    // operation and restarts with whatever is on the inputs now.
    assign accept = START;
`else
    // START is only sampled while idle; requests during RUN are dropped.
    assign accept = START && (state_q == IDLE);
`endif

    assign step = div_step(pr_q, qs_q, dvs_q);

    // Next-state and datapath update: accept/error handling and iteration.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        qs_d    = qs_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dvz_d   = dvz_q;

        if (accept) begin
            if (DIVISOR == '0) begin
                // divide by zero wins over overflow; result lands immediately
                state_d = IDLE;
                quot_d  = '1;
                rem_d   = '0;
                dvz_d   = 1'b1;
                ovf_d   = 1'b0;
            end else if (DIVIDEND[2*W-1:W] >= DIVISOR) begin
                // quotient would not fit in W bits
                state_d = IDLE;
                quot_d  = '1;
                rem_d   = '0;
                ovf_d   = 1'b1;
                dvz_d   = 1'b0;
            end else begin
                state_d = RUN;
                pr_d    = {1'b0, DIVIDEND[2*W-1:W]};
                qs_d    = DIVIDEND[W-1:0];
                dvs_d   = DIVISOR;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                dvz_d   = 1'b0;
            end
        end else if (state_q == RUN) begin
            pr_d  = step[2*W:W];
            qs_d  = step[W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
                // last iteration: publish the result and go idle
                state_d = IDLE;
                quot_d  = step[W-1:0];
                rem_d   = step[2*W-1:W];
            end
        end
    end

    // State and datapath registers; reset returns every register to zero.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            pr_q    <= '0;
            qs_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            qs_q    <= qs_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dvz_q   <= dvz_d;
        end
    end

    assign READY     = (state_q == IDLE);
    assign QUOTIENT  = quot_q;
    assign REMAINDER = rem_q;
    assign OVF       = ovf_q;
    assign DVZ       = dvz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Testbench for shift_sub_divider (W=4): table of directed vectors, an
// exhaustive sweep against an arithmetic reference, and hand-written
// sequences for back-to-back start, asynchronous reset and START during RUN.
module tb_shift_sub_divider;

    localparam int W = 4;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DIVIDEND = '0;
    logic [3:0] DIVISOR = '0;
    logic       READY;
    logic [3:0] QUOTIENT;
    logic [3:0] REMAINDER;
    logic       OVF;
    logic       DVZ;

    shift_sub_divider #(.W(W)) dut (
        .CK(CK), .RN(RN), .START(START),
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .READY(READY), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
        .OVF(OVF), .DVZ(DVZ)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dvz;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [3:0] snap_q, snap_r;
    logic       hold_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int dd, input int dv);
        exp_t e;
        e.ovf = 1'b0;
        e.dvz = 1'b0;
        if (dv == 0) begin
            e.q = 4'hF; e.r = 4'h0; e.dvz = 1'b1; e.lat = 0;
        end else if ((dd / 16) >= dv) begin
            e.q = 4'hF; e.r = 4'h0; e.ovf = 1'b1; e.lat = 0;
        end else begin
            e.q = 4'(dd / dv); e.r = 4'(dd % dv); e.lat = 4;
        end
        return e;
    endfunction

    // drive a request at the current negedge; returns at the next negedge
    task automatic start_op(input logic [7:0] dd, input logic [3:0] dv, input exp_t e);
        chk("ready_before_start", READY, 1);
        snap_q   = QUOTIENT;
        snap_r   = REMAINDER;
        hold_bad = 1'b0;
        DIVIDEND = dd;
        DIVISOR  = dv;
        START    = 1'b1;
        sb.push_back(e);
        @(negedge CK);
        START = 1'b0;
    endtask

    // count busy cycles until READY, watching that outputs hold meanwhile
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!READY && lat < 20) begin
            if (QUOTIENT !== snap_q || REMAINDER !== snap_r) hold_bad = 1'b1;
            @(negedge CK);
            lat++;
        end
        if (lat >= 20) chk("ready_timeout", lat, 0);
    endtask

    task automatic finish_op(input string name, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({name, "_ready"}, READY, 1);
        chk({name, "_q"},     QUOTIENT, e.q);
        chk({name, "_r"},     REMAINDER, e.r);
        chk({name, "_ovf"},   OVF, e.ovf);
        chk({name, "_dvz"},   DVZ, e.dvz);
        chk({name, "_lat"},   lat, e.lat);
        chk({name, "_hold"},  hold_bad, 0);
    endtask

    task automatic do_op(input string name, input logic [7:0] dd, input logic [3:0] dv, input exp_t e);
        int lat;
        @(negedge CK);
        start_op(dd, dv, e);
        wait_ready(lat);
        finish_op(name, lat);
    endtask

    function automatic exp_t mk(input int q, input int r, input int ovf, input int dvz, input int lat);
        exp_t e;
        e.q = 4'(q); e.r = 4'(r); e.ovf = ovf[0]; e.dvz = dvz[0]; e.lat = lat;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[10];
        int   lat;
        exp_t e;

        vt[0] = '{8'd100, 4'd7,  mk(14, 2, 0, 0, 4)};
        vt[1] = '{8'd119, 4'd8,  mk(14, 7, 0, 0, 4)};
        vt[2] = '{8'd15,  4'd1,  mk(15, 0, 0, 0, 4)};
        vt[3] = '{8'd255, 4'd15, mk(15, 0, 1, 0, 0)};
        vt[4] = '{8'd45,  4'd0,  mk(15, 0, 0, 1, 0)};
        vt[5] = '{8'd50,  4'd5,  mk(10, 0, 0, 0, 4)};
        vt[6] = '{8'd50,  4'd3,  mk(15, 0, 1, 0, 0)};
        vt[7] = '{8'd0,   4'd1,  mk(0,  0, 0, 0, 4)};
        vt[8] = '{8'd14,  4'd15, mk(0, 14, 0, 0, 4)};
        vt[9] = '{8'd239, 4'd15, mk(15, 14, 0, 0, 4)};

        // reset state
        #1;
        chk("rst_ready", READY, 1);
        chk("rst_q",     QUOTIENT, 0);
        chk("rst_r",     REMAINDER, 0);
        chk("rst_ovf",   OVF, 0);
        chk("rst_dvz",   DVZ, 0);
        repeat (2) @(negedge CK);
        RN = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].dd, vt[i].dv, vt[i].e);
        end

        // back-to-back: new START raised in the cycle READY rises
        @(negedge CK);
        start_op(8'd119, 4'd8, mk(14, 7, 0, 0, 4));
        wait_ready(lat);
        finish_op("b2b_first", lat);
        start_op(8'd15, 4'd1, mk(15, 0, 0, 0, 4));
        chk("b2b_no_gap", READY, 0);
        wait_ready(lat);
        finish_op("b2b_second", lat);

        // asynchronous reset during RUN
        @(negedge CK);
        start_op(8'd100, 4'd7, mk(14, 2, 0, 0, 4));
        void'(sb.pop_front());
        @(negedge CK);
        @(negedge CK);
        #2 RN = 1'b0;
        #1;
        chk("arst_ready", READY, 1);
        chk("arst_q",     QUOTIENT, 0);
        chk("arst_r",     REMAINDER, 0);
        chk("arst_ovf",   OVF, 0);
        chk("arst_dvz",   DVZ, 0);
        @(negedge CK);
        RN = 1'b1;

`ifdef DIV_ABORT_EN
        // START during RUN re-accepts 50/3, which overflows on that edge
        @(negedge CK);
        start_op(8'd100, 4'd7, mk(14, 2, 0, 0, 4));
        void'(sb.pop_front());
        @(negedge CK);
        start_op_abort(8'd50, 4'd3, mk(15, 0, 1, 0, 0));
        wait_ready(lat);
        finish_op("abort_ovf", lat);
        // START during RUN restarts with 50/5
        @(negedge CK);
        start_op(8'd100, 4'd7, mk(14, 2, 0, 0, 4));
        void'(sb.pop_front());
        @(negedge CK);
        start_op_abort(8'd50, 4'd5, mk(10, 0, 0, 0, 4));
        wait_ready(lat);
        finish_op("abort_restart", lat);
`else
        // START during RUN is ignored; inputs may change after accept
        @(negedge CK);
        start_op(8'd100, 4'd7, mk(14, 2, 0, 0, 4));
        @(negedge CK);
        DIVIDEND = 8'd50;
        DIVISOR  = 4'd3;
        START    = 1'b1;
        @(negedge CK);
        START = 1'b0;
        wait_ready(lat);
        finish_op("ignore_start", lat + 2);
`endif

        // exhaustive sweep against the arithmetic reference
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                e = model(dd, dv);
                do_op("sweep", 8'(dd), 4'(dv), e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // request issued while busy: no READY precondition, outputs snapshot kept
    task automatic start_op_abort(input logic [7:0] dd, input logic [3:0] dv, input exp_t e);
        snap_q   = QUOTIENT;
        snap_r   = REMAINDER;
        hold_bad = 1'b0;
        DIVIDEND = dd;
        DIVISOR  = dv;
        START    = 1'b1;
        sb.push_back(e);
        @(negedge CK);
        START = 1'b0;
    endtask

endmodule
